// File: rtl/riscv_types.sv
// Shared types for the rv32i core's data-side bus bridge: funct3 memory ops,
// fault codes, bridge FSM states and the access-size decode helper.
package riscv_types;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_t;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_BUSERR   = 2'b10,
        FLT_TIMEOUT  = 2'b11
    } dbus_fault_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } dbus_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } mem_size_t;

    // Unused funct3 codes (011/110/111) fall through to word.
    function automatic mem_size_t op_size(input logic [2:0] op);
        case (op)
            MEM_B, MEM_BU: return SZ_B;
            MEM_H, MEM_HU: return SZ_H;
            default:       return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/dbus_align.sv
// Combinational byte-lane logic: store select/data steering, misalignment
// detect, and load byte/half extraction with sign or zero extension.
module dbus_align
    import riscv_types::*;
(
    input  logic [1:0]  st_off,
    input  logic [2:0]  st_op,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_sel,
    output logic [31:0] st_dat,
    output logic        misalign,
    input  logic [1:0]  ld_off,
    input  logic [2:0]  ld_op,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [31:0] ld_sh;

    assign ld_sh = ld_raw >> {ld_off, 3'b000};

    always_comb begin
        st_sel   = 4'b1111;
        st_dat   = st_wdata;
        misalign = 1'b0;
        case (op_size(st_op))
            SZ_B: begin
                st_sel = 4'b0001 << st_off;
                st_dat = {4{st_wdata[7:0]}};
            end
            SZ_H: begin
                st_sel   = st_off[1] ? 4'b1100 : 4'b0011;
                st_dat   = {2{st_wdata[15:0]}};
                misalign = st_off[0];
            end
            default: misalign = |st_off;
        endcase
    end

    // ld_op[2] marks the unsigned variants; word ops with bit 2 set stay raw.
    always_comb begin
        ld_data = ld_raw;
        case (op_size(ld_op))
            SZ_B:    ld_data = ld_op[2] ? {24'h0, ld_sh[7:0]}
                                        : {{24{ld_sh[7]}}, ld_sh[7:0]};
            SZ_H:    ld_data = ld_op[2] ? {16'h0, ld_sh[15:0]}
                                        : {{16{ld_sh[15]}}, ld_sh[15:0]};
            default: ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/core_dbus_wb_bridge.sv
// MEM-stage to Wishbone classic bridge: one bus cycle per core request,
// pipeline held via stall_pipl until the access completes or faults.
module core_dbus_wb_bridge
    import riscv_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_addr_mem,
    input  logic [31:0] mem_wdata_mem,
    input  logic        mem_write_mem,
    input  logic        mem_read_mem,
    input  logic [2:0]  mem_op_mem,
    input  logic        mem_adv,
    output logic [31:0] mem_rdata_mem,
    output logic        stall_pipl,
    output logic        dbus_fault,
    output logic [1:0]  fault_code,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

    dbus_state_t state_q, state_d;
    dbus_fault_t code_q, code_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] data_q, data_d;
    logic        fault_q, fault_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;

    logic        req;
    logic [3:0]  st_sel;
    logic [31:0] st_dat;
    logic        misalign;
    logic [31:0] ld_data;

    dbus_align u_align (
        .st_off   (mem_addr_mem[1:0]),
        .st_op    (mem_op_mem),
        .st_wdata (mem_wdata_mem),
        .st_sel   (st_sel),
        .st_dat   (st_dat),
        .misalign (misalign),
        .ld_off   (off_q),
        .ld_op    (op_q),
        .ld_raw   (wb_dat_i),
        .ld_data  (ld_data)
    );

    assign req     = mem_read_mem | mem_write_mem;
    assign cnt_inc = cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        code_d  = FLT_NONE;
        fault_d = 1'b0;
        cnt_d   = cnt_q;
        data_d  = data_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        op_d    = op_q;
        off_d   = off_q;
        case (state_q)
            ST_IDLE: if (req) begin
                we_d  = mem_write_mem;
                adr_d = {mem_addr_mem[31:2], 2'b00};
                dat_d = st_dat;
                sel_d = st_sel;
                op_d  = mem_op_mem;
                off_d = mem_addr_mem[1:0];
                cnt_d = 16'd0;
                if (misalign) begin
                    state_d = ST_DONE;
                    data_d  = 32'h0;
                    fault_d = 1'b1;
                    code_d  = FLT_MISALIGN;
                end else begin
                    state_d = ST_BUS;
                    cyc_d   = 1'b1;
                end
            end
            ST_BUS: begin
                cnt_d = cnt_inc;
                // err wins over ack; timeout only when the slave stayed silent
                if (wb_err_i) begin
                    state_d = ST_DONE;
                    cyc_d   = 1'b0;
                    data_d  = 32'h0;
                    fault_d = 1'b1;
                    code_d  = FLT_BUSERR;
                end else if (wb_ack_i) begin
                    state_d = ST_DONE;
                    cyc_d   = 1'b0;
                    data_d  = we_q ? 32'h0 : ld_data;
                end else if (cnt_inc == TO_LIM) begin
                    state_d = ST_DONE;
                    cyc_d   = 1'b0;
                    data_d  = 32'h0;
                    fault_d = 1'b1;
                    code_d  = FLT_TIMEOUT;
                end
            end
            ST_DONE: if (mem_adv) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            code_q  <= FLT_NONE;
            fault_q <= 1'b0;
            cnt_q   <= 16'd0;
            data_q  <= 32'h0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
            sel_q   <= 4'h0;
            op_q    <= 3'b000;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            off_q   <= off_d;
        end
    end

    // The core keeps its request asserted while frozen, so reset must mask it.
    assign stall_pipl    = reset_n & (((state_q == ST_IDLE) & req) | (state_q == ST_BUS));
    assign mem_rdata_mem = data_q;
    assign dbus_fault    = fault_q;
    assign fault_code    = code_q;
    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = cyc_q;
    assign wb_we_o       = we_q;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign wb_sel_o      = sel_q;

endmodule

// File: tb/tb_core_dbus_wb_bridge.sv
// Directed bench for core_dbus_wb_bridge with a small Wishbone slave whose
// wait count, termination kind and read data are set per access.
module tb_core_dbus_wb_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] mem_addr_mem = '0;
    logic [31:0] mem_wdata_mem = '0;
    logic        mem_write_mem = 1'b0;
    logic        mem_read_mem = 1'b0;
    logic [2:0]  mem_op_mem = 3'b000;
    logic        mem_adv = 1'b0;
    logic [31:0] mem_rdata_mem;
    logic        stall_pipl;
    logic        dbus_fault;
    logic [1:0]  fault_code;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i;

    // slave: mode 0 = ack, 1 = err, 2 = silent; terminates in BUS cycle sl_wait+1
    int          sl_mode = 0;
    int          sl_wait = 0;
    int          sl_cnt = 0;
    logic [31:0] sl_rdata = '0;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_stall, n_cyc;
    logic [31:0] cap_adr, cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;
    logic [31:0] got_rd;
    logic        got_flt;
    logic [1:0]  got_code;

    always #5 clk = ~clk;

    always @(posedge clk) sl_cnt <= wb_cyc_o ? sl_cnt + 1 : 0;

    assign wb_dat_i = sl_rdata;
    assign wb_ack_i = wb_cyc_o && wb_stb_o && sl_mode == 0 && sl_cnt == sl_wait;
    assign wb_err_i = wb_cyc_o && wb_stb_o && sl_mode == 1 && sl_cnt == sl_wait;

    core_dbus_wb_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_addr_mem  (mem_addr_mem),
        .mem_wdata_mem (mem_wdata_mem),
        .mem_write_mem (mem_write_mem),
        .mem_read_mem  (mem_read_mem),
        .mem_op_mem    (mem_op_mem),
        .mem_adv       (mem_adv),
        .mem_rdata_mem (mem_rdata_mem),
        .stall_pipl    (stall_pipl),
        .dbus_fault    (dbus_fault),
        .fault_code    (fault_code),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_sel_o      (wb_sel_o),
        .wb_dat_i      (wb_dat_i),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE and follow it to the first DONE cycle,
    // counting stall and cyc cycles and capturing the bus signals.
    task automatic run_acc(input logic w, input logic r, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] d);
        mem_write_mem = w;
        mem_read_mem  = r;
        mem_op_mem    = op;
        mem_addr_mem  = a;
        mem_wdata_mem = d;
        n_stall = 0;
        n_cyc   = 0;
        cap_adr = '0; cap_dat = '0; cap_sel = '0; cap_we = 1'b0;
        #1;
        while (stall_pipl && n_stall < 100) begin
            n_stall++;
            tick();
            if (wb_cyc_o) begin
                n_cyc++;
                cap_adr = wb_adr_o;
                cap_dat = wb_dat_o;
                cap_sel = wb_sel_o;
                cap_we  = wb_we_o;
            end
        end
        got_rd   = mem_rdata_mem;
        got_flt  = dbus_fault;
        got_code = fault_code;
    endtask

    // Core advances out of DONE; next cycle is IDLE with no request yet.
    task automatic adv();
        mem_adv = 1'b1;
        tick();
        mem_adv       = 1'b0;
        mem_write_mem = 1'b0;
        mem_read_mem  = 1'b0;
        chk("idle_cyc_low", {31'h0, wb_cyc_o}, 32'h0);
    endtask

    initial begin
        #1;
        chk("rst_cyc",   {31'h0, wb_cyc_o}, 32'h0);
        chk("rst_stb",   {31'h0, wb_stb_o}, 32'h0);
        chk("rst_stall", {31'h0, stall_pipl}, 32'h0);
        chk("rst_rdata", mem_rdata_mem, 32'h0);
        chk("rst_fault", {29'h0, dbus_fault, fault_code}, 32'h0);
        chk("rst_bus",   {wb_adr_o[31:5] ^ wb_dat_o[26:0], wb_sel_o, wb_we_o}, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // sw 0xDEADBEEF -> 0x104, zero wait
        sl_mode = 0; sl_wait = 0; sl_rdata = 32'h0;
        run_acc(1'b1, 1'b0, 3'b010, 32'h104, 32'hDEADBEEF);
        chk("sw_adr",   cap_adr, 32'h104);
        chk("sw_sel",   {28'h0, cap_sel}, 32'hF);
        chk("sw_dat",   cap_dat, 32'hDEADBEEF);
        chk("sw_we",    {31'h0, cap_we}, 32'h1);
        chk("sw_stall", n_stall, 2);
        chk("sw_fault", {31'h0, got_flt}, 32'h0);
        adv();

        // lb 0x203, ack in third BUS cycle
        sl_wait = 2; sl_rdata = 32'h80FF_FF7F;
        run_acc(1'b0, 1'b1, 3'b000, 32'h203, 32'h0);
        chk("lb_data",  got_rd, 32'hFFFF_FF80);
        chk("lb_stall", n_stall, 4);
        chk("lb_sel",   {28'h0, cap_sel}, 32'h8);
        chk("lb_adr",   cap_adr, 32'h200);
        chk("lb_we",    {31'h0, cap_we}, 32'h0);
        adv();

        // lbu same address, 3 wait states
        sl_wait = 3;
        run_acc(1'b0, 1'b1, 3'b100, 32'h203, 32'h0);
        chk("lbu_data",  got_rd, 32'h0000_0080);
        chk("lbu_stall", n_stall, 5);
        adv();

        sl_wait = 0;
        run_acc(1'b0, 1'b1, 3'b001, 32'h202, 32'h0);
        chk("lh_hi_data", got_rd, 32'hFFFF_80FF);
        adv();
        run_acc(1'b0, 1'b1, 3'b101, 32'h200, 32'h0);
        chk("lhu_lo_data", got_rd, 32'h0000_FF7F);
        adv();
        run_acc(1'b0, 1'b1, 3'b111, 32'h200, 32'h0);
        chk("op111_word", got_rd, 32'h80FF_FF7F);
        adv();

        // read+write together behave as a store and return 0
        run_acc(1'b1, 1'b1, 3'b010, 32'h40, 32'h5555AAAA);
        chk("rw_we",    {31'h0, cap_we}, 32'h1);
        chk("rw_rdata", got_rd, 32'h0);
        adv();

        run_acc(1'b1, 1'b0, 3'b001, 32'h302, 32'h0000_1234);
        chk("sh_sel", {28'h0, cap_sel}, 32'hC);
        chk("sh_dat", cap_dat, 32'h1234_1234);
        adv();
        run_acc(1'b1, 1'b0, 3'b000, 32'h101, 32'h0000_00AB);
        chk("sb_sel", {28'h0, cap_sel}, 32'h2);
        chk("sb_dat", cap_dat, 32'hABAB_ABAB);
        adv();

        // misaligned lh 0x301
        run_acc(1'b0, 1'b1, 3'b001, 32'h301, 32'h0);
        chk("mis_cyc",   n_cyc, 0);
        chk("mis_stall", n_stall, 1);
        chk("mis_fault", {29'h0, got_flt, got_code}, 32'h5);
        adv();
        run_acc(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
        chk("misw_fault", {29'h0, got_flt, got_code}, 32'h5);
        chk("misw_cyc",   n_cyc, 0);
        adv();

        // lw with err in second BUS cycle
        sl_mode = 1; sl_wait = 1;
        run_acc(1'b0, 1'b1, 3'b010, 32'h200, 32'h0);
        chk("err_fault", {29'h0, got_flt, got_code}, 32'h6);
        chk("err_data",  got_rd, 32'h0);
        chk("err_cyc",   n_cyc, 2);
        chk("err_cyc_now", {31'h0, wb_cyc_o}, 32'h0);
        tick();
        chk("err_pulse", {31'h0, dbus_fault}, 32'h0);
        adv();

        // silent slave, TIMEOUT_CYCLES = 8
        sl_mode = 2;
        run_acc(1'b0, 1'b1, 3'b010, 32'h200, 32'h0);
        chk("to_cyc",   n_cyc, 8);
        chk("to_stall", n_stall, 9);
        chk("to_fault", {29'h0, got_flt, got_code}, 32'h7);
        chk("to_data",  got_rd, 32'h0);
        adv();

        // DONE held with mem_adv low: no reissue, data stable
        sl_mode = 0; sl_wait = 0; sl_rdata = 32'h1357_9BDF;
        run_acc(1'b0, 1'b1, 3'b010, 32'h80, 32'h0);
        chk("hold_data0", got_rd, 32'h1357_9BDF);
        sl_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_cyc",   {31'h0, wb_cyc_o}, 32'h0);
            chk("hold_stall", {31'h0, stall_pipl}, 32'h0);
            chk("hold_data",  mem_rdata_mem, 32'h1357_9BDF);
        end
        adv();

        // reset asserted mid-BUS
        sl_mode = 2;
        mem_read_mem = 1'b1; mem_op_mem = 3'b010; mem_addr_mem = 32'h200;
        tick();
        chk("rstbus_cyc_pre", {31'h0, wb_cyc_o}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstbus_cyc",   {31'h0, wb_cyc_o}, 32'h0);
        chk("rstbus_stb",   {31'h0, wb_stb_o}, 32'h0);
        chk("rstbus_stall", {31'h0, stall_pipl}, 32'h0);
        mem_read_mem = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("rstbus_after", {31'h0, wb_cyc_o, stall_pipl}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
